// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/mux2x1.sv
// Generic two-input multiplexer: out = sel ? inp2 : inp1.
module mux2x1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign out[gi] = sel ? inp2[gi] : inp1[gi];
        end
    endgenerate

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues one imem request at a time
// and presents the fetched instruction to IF/ID; EX redirects flush the fetch.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         if_valid_reg, if_valid_next;
    logic [31:0]  if_pc_reg, if_pc_next;
    logic [31:0]  if_instr_reg, if_instr_next;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_aligned;
    logic [31:0]  mux_pc;
    logic         req_fire;

    assign pc_plus4         = pc_reg + PC_STEP;
    assign redirect_aligned = redirect_pc & ~32'h0000_0003;
    assign req_fire         = (state_reg == REQ) && imem_req_ready;

    mux2x1 #(.WIDTH(32)) u_next_pc_mux (
        .inp1 (pc_plus4),
        .inp2 (redirect_aligned),
        .sel  (redirect_valid),
        .out  (mux_pc)
    );

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        if_valid_next = if_valid_reg;
        if_pc_next    = if_pc_reg;
        if_instr_next = if_instr_reg;

        // A redirect always reloads the PC, including during BOOT.
        if (redirect_valid || req_fire) begin
            pc_next = mux_pc;
        end

        case (state_reg)
            BOOT: state_next = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_next = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_next = imem_rsp_valid ? REQ : DROP;
                end else if (imem_rsp_valid) begin
                    // pc already points past the fetched word
                    if_valid_next = 1'b1;
                    if_pc_next    = pc_reg - PC_STEP;
                    if_instr_next = imem_rsp_data;
                    state_next    = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || if_ready) begin
                    if_valid_next = 1'b0;
                    state_next    = REQ;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            if_valid_reg <= 1'b0;
            if_pc_reg    <= '0;
            if_instr_reg <= NOP_INSTR;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            if_valid_reg <= if_valid_next;
            if_pc_reg    <= if_pc_next;
            if_instr_reg <= if_instr_next;
        end
    end

    assign imem_req_valid = (state_reg == REQ);
    assign imem_req_addr  = pc_reg;
    assign if_valid       = if_valid_reg;
    assign if_pc          = if_pc_reg;
    assign if_instr       = if_instr_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: fetch seen as transactions, not as FSM states.
    bit          m_boot;   // first cycle after reset release
    logic [31:0] m_pc;     // next fetch address
    bit          m_busy;   // a request is in flight
    bit          m_live;   // in-flight request will be delivered
    logic [31:0] m_addr;   // address of in-flight request
    bit          m_pres;   // instruction presented to IF/ID
    logic [31:0] m_ppc;
    logic [31:0] m_pinstr;

    logic [31:0] req_log[$];
    logic [31:0] del_log[$];
    logic [31:0] del_instr_log[$];
    int          req_seen;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot   = 1'b1;
        m_pc     = RST_PC;
        m_busy   = 1'b0;
        m_live   = 1'b0;
        m_addr   = '0;
        m_pres   = 1'b0;
        m_ppc    = '0;
        m_pinstr = NOP_INSTR;
    endtask

    task automatic model_step(input bit redir, input logic [31:0] rpc, input bit rdy,
                              input bit rspv, input logic [31:0] data, input bit ifr);
        logic [31:0] tgt;
        bit can_req, hs, got;
        tgt = {rpc[31:2], 2'b00};
        if (m_boot) begin
            m_boot = 1'b0;
            if (redir) m_pc = tgt;
            return;
        end
        can_req = !m_busy && !m_pres;
        hs      = can_req && rdy;
        got     = m_busy && rspv;
        if (redir) begin
            m_pres = 1'b0;
            if (hs) begin
                m_busy = 1'b1;
                m_live = 1'b0;
            end else if (got) begin
                m_busy = 1'b0;
            end else begin
                m_live = 1'b0;
            end
            m_pc = tgt;
        end else begin
            if (m_pres && ifr) m_pres = 1'b0;
            if (got) begin
                m_busy = 1'b0;
                if (m_live) begin
                    m_pres   = 1'b1;
                    m_ppc    = m_addr;
                    m_pinstr = data;
                end
            end
            if (hs) begin
                m_busy = 1'b1;
                m_live = 1'b1;
                m_addr = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        bit exp_req;
        exp_req = !m_boot && !m_busy && !m_pres;
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
        if (exp_req) chk("req_addr", imem_req_addr, m_pc);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_pres});
        chk("if_pc", if_pc, m_ppc);
        chk("if_instr", if_instr, m_pinstr);
    endtask

    // One clock: compare at the falling edge, drive inputs, advance the model.
    task automatic cycle(input bit rin, input bit redir, input logic [31:0] rpc, input bit rdy,
                         input bit rspv, input bit ifr, input logic [31:0] data);
        @(negedge clk);
        compare();
        rst            = rin;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        imem_rsp_valid = rspv;
        imem_rsp_data  = data;
        if_ready       = ifr;
        if (!rin && imem_req_valid) req_seen++;
        if (!rin && imem_req_valid && rdy) req_log.push_back(imem_req_addr);
        if (!rin && if_valid && ifr && !redir) begin
            del_log.push_back(if_pc);
            del_instr_log.push_back(if_instr);
        end
        if (rin) model_reset();
        else     model_step(redir, rpc, rdy, rspv, data, ifr);
    endtask

    // Idle traffic with a one-cycle memory.
    task automatic run(input int n, input bit rdy, input bit ifr);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, rdy, m_busy, ifr, imem_word(m_addr));
    endtask

    task automatic clear_logs();
        req_log.delete();
        del_log.delete();
        del_instr_log.delete();
        req_seen = 0;
    endtask

    task automatic wait_in_flight(input string name);
        int k = 0;
        while (!(m_busy && m_live) && k < 20) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0);
            k++;
        end
        chk(name, {31'd0, (m_busy && m_live)}, 32'd1);
    endtask

    task automatic wait_can_req(input string name);
        int k = 0;
        while ((m_boot || m_busy || m_pres) && k < 20) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0, m_busy, 1'b1, imem_word(m_addr));
            k++;
        end
        chk(name, {31'd0, !(m_boot || m_busy || m_pres)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held_pc, held_instr;
        int k;

        // Reset state
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0100);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Sequential fetch from RESET_PC
        clear_logs();
        run(12, 1'b1, 1'b1);
        chk("seq_nreq", {31'd0, req_log.size() >= 3}, 32'd1);
        chk("seq_ndel", {31'd0, del_log.size() >= 3}, 32'd1);
        chk("seq_req0", req_log[0], 32'h0000_0100);
        chk("seq_req1", req_log[1], 32'h0000_0104);
        chk("seq_req2", req_log[2], 32'h0000_0108);
        chk("seq_pc0", del_log[0], 32'h0000_0100);
        chk("seq_pc1", del_log[1], 32'h0000_0104);
        chk("seq_pc2", del_log[2], 32'h0000_0108);
        chk("seq_instr0", del_instr_log[0], imem_word(32'h0000_0100));
        chk("seq_instr2", del_instr_log[2], imem_word(32'h0000_0108));

        // Stall in HOLD for five cycles
        k = 0;
        while (!m_pres && k < 12) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1, m_busy, 1'b0, imem_word(m_addr));
            k++;
        end
        chk("stall_reach", {31'd0, m_pres}, 32'd1);
        held_pc    = m_ppc;
        held_instr = m_pinstr;
        clear_logs();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("stall_reqs", req_seen, 32'd0);
        chk("stall_pc", if_pc, held_pc);
        chk("stall_instr", if_instr, held_instr);
        clear_logs();
        run(6, 1'b1, 1'b1);
        chk("resume_pc0", del_log[0], held_pc);
        chk("resume_pc1", del_log[1], held_pc + 32'd4);

        // Redirect while waiting for a response
        wait_in_flight("wait_reach");
        clear_logs();
        cycle(1'b0, 1'b1, 32'h0000_2003, 1'b0, 1'b0, 1'b1, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        run(8, 1'b1, 1'b1);
        chk("redir_wait_req", req_log[0], 32'h0000_2000);
        chk("redir_wait_pc", del_log[0], 32'h0000_2000);

        // Redirect coinciding with the request handshake
        wait_can_req("hs_reach");
        cycle(1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 1'b1, 32'd0);
        clear_logs();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hBAD0_BAD0);
        run(8, 1'b1, 1'b1);
        chk("redir_hs_req", req_log[0], 32'h0000_3000);
        chk("redir_hs_pc", del_log[0], 32'h0000_3000);

        // PC wrap-around
        wait_can_req("wrap_reach");
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'd0);
        clear_logs();
        run(8, 1'b1, 1'b1);
        chk("wrap_req0", req_log[0], 32'hFFFF_FFFC);
        chk("wrap_req1", req_log[1], 32'h0000_0000);
        chk("wrap_pc1", del_log[1], 32'h0000_0000);

        // Asynchronous reset during WAIT, then a late response
        wait_in_flight("rstwait_reach");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("arst_req_addr", imem_req_addr, 32'h0000_0100);
        chk("arst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_if_pc", if_pc, 32'd0);
        chk("arst_if_instr", if_instr, 32'h0000_0013);
        model_reset();
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1111_1111);
        clear_logs();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h2222_2222);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h3333_3333);
        run(6, 1'b1, 1'b1);
        chk("arst_first_req", req_log[0], 32'h0000_0100);
        chk("arst_first_pc", del_log[0], 32'h0000_0100);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          rin, redir, rdy, rspv, ifr;
            logic [31:0] rpc, data;
            rin   = ($urandom_range(0, 299) == 0);
            redir = ($urandom_range(0, 9) == 0);
            rpc   = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            rdy   = ($urandom_range(0, 9) < 6);
            ifr   = ($urandom_range(0, 9) < 7);
            if (m_busy) begin
                rspv = ($urandom_range(0, 1) == 0);
                data = imem_word(m_addr);
            end else begin
                rspv = ($urandom_range(0, 19) == 0);
                data = $urandom;
            end
            cycle(rin, redir, rpc, rdy, rspv, ifr, data);
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
